// File: rtl/accum_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// accum_sequencer_pkg
// Shared definitions for the accumulation sequencer slice: default operand and
// count widths, plus the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package accum_sequencer_pkg;

    // Default operand/result width; must match the ripple adder instance width.
    localparam int unsigned N_DEF     = 4;
    // Default operand-count width; a run holds at most 2^CNT_W-1 operands.
    localparam int unsigned CNT_W_DEF = 4;

    // Controller state encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage : accum_sequencer_pkg

// File: rtl/accum_sequencer_if.sv
// -----------------------------------------------------------------------------
// accum_sequencer_if
// Bundles the run-control, operand stream, adder hookup and status signals of
// the accumulation sequencer.
//   start/len            : run request and operand count
//   in_valid/in_data     : operand stream, in_ready is the accept back-pressure
//   add_a/add_b/add_ci   : operands driven to the external combinational adder
//   add_sum/add_co       : adder results consumed by the sequencer
//   result/ovf/busy/done : status presented to the requester
// Modports: slave = the sequencer, master = its surrounding parent/requester.
// -----------------------------------------------------------------------------
import accum_sequencer_pkg::*;

interface accum_sequencer_if #(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_ci;
    logic [N-1:0]     add_sum;
    logic             add_co;
    logic [N-1:0]     result;
    logic             ovf;
    logic             busy;
    logic             done;

    modport slave (
        input  start, len, in_valid, in_data, add_sum, add_co,
        output in_ready, add_a, add_b, add_ci, result, ovf, busy, done
    );

    modport master (
        output start, len, in_valid, in_data, add_sum, add_co,
        input  in_ready, add_a, add_b, add_ci, result, ovf, busy, done
    );

endinterface : accum_sequencer_if

// File: rtl/accum_sequencer_reg.sv
// -----------------------------------------------------------------------------
// accum_reg
// Datapath register of the sequencer: N-bit accumulator with synchronous
// clear/load and a sticky flag that ORs in flag_set_i on every load.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr_i         : clear accumulator and flag (wins over load_i)
//   load_i        : capture d_i, OR flag_set_i into the flag
//   d_i           : next accumulator value
//   flag_set_i    : flag set request, only honoured together with load_i
//   acc_o, flag_o : registered accumulator and sticky flag
// -----------------------------------------------------------------------------
import accum_sequencer_pkg::*;

module accum_reg #(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [N-1:0] d_i,
    input  logic         flag_set_i,
    output logic [N-1:0] acc_o,
    output logic         flag_o
);

    logic [N-1:0] acc_q;
    logic [N-1:0] acc_d;
    logic         flag_q;
    logic         flag_d;

    // Next-state selection: clear has priority so a new run starts from zero.
    always_comb begin
        acc_d  = acc_q;
        flag_d = flag_q;
        if (clr_i) begin
            acc_d  = {N{1'b0}};
            flag_d = 1'b0;
        end else if (load_i) begin
            acc_d  = d_i;
            flag_d = flag_q | flag_set_i;
        end else begin
            acc_d  = acc_q;
            flag_d = flag_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= {N{1'b0}};
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end

    assign acc_o  = acc_q;
    assign flag_o = flag_q;

endmodule : accum_reg

// File: rtl/accum_sequencer.sv
// -----------------------------------------------------------------------------
// accum_sequencer
// Sequential accumulation controller around an external N-bit combinational
// ripple adder. Sums len operands received over a valid/ready stream, then
// reports the registered total, a sticky carry-out flag and a one-cycle done.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : accum_sequencer_if.slave (control, stream, adder hookup, status)
// The adder sits beside this block in the parent: add_a carries the
// accumulator, add_b passes in_data straight through, add_ci is tied low.
// -----------------------------------------------------------------------------
import accum_sequencer_pkg::*;

module accum_sequencer #(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    accum_sequencer_if.slave   bus
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic             done_q;
    logic             done_d;

    logic             xfer_s;
    logic             clr_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [N-1:0]     acc_s;
    logic             ovf_s;

    // An operand is consumed only while accumulating and the source is valid.
    assign xfer_s    = (state_q == ACCUM) && bus.in_valid;
    // cnt never wraps: len_q caps the run below 2^CNT_W.
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Controller next-state, count and length capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        clr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr_s = 1'b1;
                    len_d = bus.len;
                    cnt_d = {CNT_W{1'b0}};
                    if (bus.len == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (xfer_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == len_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // done is registered from the next state so it is high exactly while in DONE.
    always_comb begin
        if (state_d == DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // Controller state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            len_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    accum_reg #(
        .N (N)
    ) u_accum_reg (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_s),
        .load_i     (xfer_s),
        .d_i        (bus.add_sum),
        .flag_set_i (bus.add_co),
        .acc_o      (acc_s),
        .flag_o     (ovf_s)
    );

    assign bus.add_a    = acc_s;
    assign bus.add_b    = bus.in_data;
    assign bus.add_ci   = 1'b0;
    assign bus.result   = acc_s;
    assign bus.ovf      = ovf_s;
    assign bus.busy     = (state_q == ACCUM);
    assign bus.in_ready = (state_q == ACCUM);
    assign bus.done     = done_q;

endmodule : accum_sequencer
